// File: rtl/shift_rotate_pkg.sv
// Op codes and FSM encoding shared by the sequential shift/rotate unit.
package shift_rotate_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_RCL  = 3'b101;
  localparam logic [2:0] OP_RCR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate: next value and the bit moved out (or across carry).
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             carry,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_value,
  output logic             next_carry
);

  always_comb begin
    next_value = value;
    next_carry = 1'b0;
    case (op)
      OP_SLL: begin next_value = {value[WIDTH-2:0], 1'b0};         next_carry = value[WIDTH-1]; end
      OP_SRL: begin next_value = {1'b0, value[WIDTH-1:1]};         next_carry = value[0];       end
      OP_ROL: begin next_value = {value[WIDTH-2:0], value[WIDTH-1]}; next_carry = value[WIDTH-1]; end
      OP_ROR: begin next_value = {value[0], value[WIDTH-1:1]};     next_carry = value[0];       end
      OP_SRA: begin next_value = {value[WIDTH-1], value[WIDTH-1:1]}; next_carry = value[0];     end
      // RCL/RCR rotate a WIDTH+1 bit ring whose extra bit is the carry
      OP_RCL: begin next_value = {value[WIDTH-2:0], carry};        next_carry = value[WIDTH-1]; end
      OP_RCR: begin next_value = {carry, value[WIDTH-1:1]};        next_carry = value[0];       end
      default: begin next_value = value;                           next_carry = 1'b0;           end
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate: captures an operand on start, moves it one bit per
// clock, then pulses done with registered result/c/z.
module shift_rotate_seq
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       operation,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z
);

  state_t           state;
  logic [WIDTH-1:0] work_val;
  logic             work_c;
  logic [2:0]       work_op;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] step_val;
  logic             step_c;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (work_val),
    .carry      (work_c),
    .op         (work_op),
    .next_value (step_val),
    .next_carry (step_c)
  );

  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      work_val  <= '0;
      work_c    <= 1'b0;
      work_op   <= OP_SLL;
      remaining <= '0;
      result    <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_val  <= data;
            work_c    <= cin;
            work_op   <= operation;
            remaining <= shift_count;
            if (shift_count == '0) begin
              // zero count is a pure pass-through, carry cleared for every op
              result <= data;
              c      <= 1'b0;
              z      <= (data == '0);
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_val  <= step_val;
          work_c    <= step_c;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            result <= step_val;
            c      <= step_c;
            z      <= (step_val == '0);
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench: driver pushes hand-computed results, monitor checks on done.
module tb_shift_rotate_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] data;
  logic [2:0]       operation;
  logic             cin;
  logic             ready, busy, done, c, z;
  logic [WIDTH-1:0] result;

  shift_rotate_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_count(shift_count),
    .data(data), .operation(operation), .cin(cin), .ready(ready),
    .busy(busy), .done(done), .result(result), .c(c), .z(z)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             zf;
    int               due;
    string            name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_c"}, 32'(c), 32'(e.cy));
        chk({e.name, "_z"}, 32'(z), 32'(e.zf));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive one start; returns at the negedge following the accepting edge.
  task automatic issue(input string name, input logic [7:0] d, input logic [2:0] op,
                       input logic ci, input int cnt, input logic expect_done,
                       input logic [7:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    start = 1'b1; data = d; operation = op; cin = ci; shift_count = CNT_W'(cnt);
    @(posedge clk);
    #1;
    if (expect_done) begin
      e.res = er; e.cy = ec; e.zf = (er == 8'h00); e.due = cyc + cnt; e.name = name;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; data = 8'hxx; operation = 3'bxxx; cin = 1'bx;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk({name, "_timeout"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; operation = '0; cin = 1'b0; shift_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 1); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);   chk("rst_result", 32'(result), 0);
    chk("rst_c", 32'(c), 0);         chk("rst_z", 32'(z), 0);
    rst = 1'b0;

    // SLL 5 by 2, busy through the DONE cycle
    issue("sll2", 8'd5, 3'b000, 1'b0, 2, 1'b1, 8'b00010100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sll2_busy", 32'(busy), 1);
      @(negedge clk);
    end
    chk("sll2_ready_after", 32'(ready), 1);
    chk("sll2_busy_after", 32'(busy), 0);

    issue("rol2", 8'b01001100, 3'b010, 1'b0, 2, 1'b1, 8'b00110001, 1'b1); wait_idle("rol2");
    issue("ror2", 8'b01001100, 3'b011, 1'b0, 2, 1'b1, 8'b00010011, 1'b0); wait_idle("ror2");
    issue("sra2", 8'd134, 3'b100, 1'b0, 2, 1'b1, 8'b11100001, 1'b1);      wait_idle("sra2");
    issue("srl2", 8'd134, 3'b001, 1'b0, 2, 1'b1, 8'b00100001, 1'b1);      wait_idle("srl2");
    issue("rcl1", 8'h80, 3'b101, 1'b1, 1, 1'b1, 8'h01, 1'b1);            wait_idle("rcl1");
    issue("rcr1", 8'h01, 3'b110, 1'b1, 1, 1'b1, 8'h80, 1'b1);            wait_idle("rcr1");
    issue("rcl0", 8'hA5, 3'b101, 1'b1, 0, 1'b1, 8'hA5, 1'b0);            wait_idle("rcl0");
    issue("sll0", 8'hA5, 3'b000, 1'b0, 0, 1'b1, 8'hA5, 1'b0);            wait_idle("sll0");
    issue("rsvd3", 8'h3C, 3'b111, 1'b1, 3, 1'b1, 8'h3C, 1'b0);           wait_idle("rsvd3");

    // Second start while busy must be ignored
    issue("sll7", 8'h01, 3'b000, 1'b0, 7, 1'b1, 8'h80, 1'b0);
    start = 1'b1; data = 8'hFF; operation = 3'b001; shift_count = 3'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle("sll7");
    chk("sll7_hold_result", 32'(result), 32'h80);

    issue("sll1_zero", 8'h80, 3'b000, 1'b0, 1, 1'b1, 8'h00, 1'b1); wait_idle("sll1_zero");

    // Abort mid-operation: no done pulse, outputs back to reset values
    issue("srl7_abort", 8'hFF, 3'b001, 1'b0, 7, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 1); chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0); chk("abort_c", 32'(c), 0);
    chk("abort_z", 32'(z), 0);
    repeat (10) @(negedge clk);

    // rst and start together: nothing captured
    rst = 1'b1; start = 1'b1; data = 8'h55; operation = 3'b000; shift_count = 3'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_ready", 32'(ready), 1);
    repeat (3) @(negedge clk);

    issue("post_abort", 8'h81, 3'b010, 1'b0, 1, 1'b1, 8'h03, 1'b1); wait_idle("post_abort");

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
